// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter: grants whole bus cycles to M0 (data) or M1 (fetch).
// Optional watchdog that force-terminates a stalled grant: define WB_ARB_TIMEOUT_EN.
module wb_dual_master_arbiter #(
  parameter int unsigned PRIORITY       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic        arb_timeout_o
`endif
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_M0 = 2'd1,
    ST_GNT_M1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_grant;
  logic   w_last_grant_nxt;
  logic   w_m0_req;
  logic   w_m1_req;
  logic   w_gnt_cyc;
  logic   w_tmo;

  assign w_m0_req = m0_cyc_i & m0_stb_i;
  assign w_m1_req = m1_cyc_i & m1_stb_i;

  always_comb begin
    w_gnt_cyc = 1'b0;
    case (r_state)
      ST_GNT_M0: w_gnt_cyc = m0_cyc_i;
      ST_GNT_M1: w_gnt_cyc = m1_cyc_i;
      default:   w_gnt_cyc = 1'b0;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  // Watchdog: zero on the first granted cycle, cleared by any slave ack.
  logic [TMO_W-1:0] r_wdt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt <= '0;
    end else if (r_state == ST_IDLE || s_ack_i) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + TMO_W'(1);
    end
  end

  assign w_tmo = w_gnt_cyc & ~s_ack_i & (r_wdt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TMO_W, TIMEOUT_CYCLES};
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next state: arbitrate only from IDLE, so every grant is followed by one idle cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_m0_req && w_m1_req) begin
          if (PRIORITY == 0 || r_last_grant) begin
            w_state_nxt      = ST_GNT_M0;
            w_last_grant_nxt = 1'b0;
          end else begin
            w_state_nxt      = ST_GNT_M1;
            w_last_grant_nxt = 1'b1;
          end
        end else if (w_m0_req) begin
          w_state_nxt      = ST_GNT_M0;
          w_last_grant_nxt = 1'b0;
        end else if (w_m1_req) begin
          w_state_nxt      = ST_GNT_M1;
          w_last_grant_nxt = 1'b1;
        end
      end
      ST_GNT_M0, ST_GNT_M1: begin
        if (!w_gnt_cyc || w_tmo) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus mux; acks are only forwarded while the granted master is strobing.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
`ifdef WB_ARB_TIMEOUT_EN
    arb_timeout_o = 1'b0;
`endif
    case (r_state)
      ST_GNT_M0: begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_stb_o   = m0_stb_i;
        s_cyc_o   = m0_cyc_i;
        m0_ack_o  = s_ack_i & m0_cyc_i & m0_stb_i;
        m0_data_o = s_data_i;
      end
      ST_GNT_M1: begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_stb_o   = m1_stb_i;
        s_cyc_o   = m1_cyc_i;
        m1_ack_o  = s_ack_i & m1_cyc_i & m1_stb_i;
        m1_data_o = s_data_i;
      end
      default: ;
    endcase
`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog expiry: terminate the master with an error-free empty ack.
    if (w_tmo) begin
      s_stb_o       = 1'b0;
      s_cyc_o       = 1'b0;
      arb_timeout_o = 1'b1;
      if (r_state == ST_GNT_M0) begin
        m0_ack_o  = 1'b1;
        m0_data_o = '0;
      end else begin
        m1_ack_o  = 1'b1;
        m1_data_o = '0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Bench: fixed-priority and round-robin arbiters driven in parallel, checked against an ownership model.
module tb_wb_dual_master_arbiter;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;
  logic [3:0]  m0_sel, m1_sel;

  logic [31:0] s_addr_o [2];
  logic [31:0] s_data_o [2];
  logic [31:0] m0_data_o [2];
  logic [31:0] m1_data_o [2];
  logic [3:0]  s_sel_o [2];
  logic        s_we_o [2];
  logic        s_stb_o [2];
  logic        s_cyc_o [2];
  logic        m0_ack_o [2];
  logic        m1_ack_o [2];
`ifdef WB_ARB_TIMEOUT_EN
  logic        tmo_o [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_dual_master_arbiter #(.PRIORITY(g), .TIMEOUT_CYCLES(TMO)) u_dut (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
      .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_data_o(m0_data_o[g]), .m0_ack_o(m0_ack_o[g]),
      .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
      .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_data_o(m1_data_o[g]), .m1_ack_o(m1_ack_o[g]),
      .s_addr_o(s_addr_o[g]), .s_data_o(s_data_o[g]), .s_we_o(s_we_o[g]), .s_sel_o(s_sel_o[g]),
      .s_stb_o(s_stb_o[g]), .s_cyc_o(s_cyc_o[g]), .s_data_i(s_rdat), .s_ack_i(s_ack)
`ifdef WB_ARB_TIMEOUT_EN
      , .arb_timeout_o(tmo_o[g])
`endif
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), who was granted last, cycles since grant/ack.
  int own [2]  = '{-1, -1};
  int last [2] = '{1, 1};
  int cnt [2]  = '{0, 0};

  function automatic logic owner_cyc(int k);
    return (own[k] == 0) ? m0_cyc : (own[k] == 1) ? m1_cyc : 1'b0;
  endfunction

  function automatic logic timed_out(int k);
`ifdef WB_ARB_TIMEOUT_EN
    return own[k] >= 0 && owner_cyc(k) && !s_ack && cnt[k] == TMO - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [137:0] exp_vec(int k);
    logic [31:0] a, d, d0, d1;
    logic [3:0]  sel;
    logic        we, stb, cyc, a0, a1, t;
    {a, d, d0, d1, sel, we, stb, cyc, a0, a1} = '0;
    if (own[k] == 0) begin
      {a, d, we, sel, stb, cyc} = {m0_addr, m0_wdat, m0_we, m0_sel, m0_stb, m0_cyc};
      a0 = s_ack && m0_cyc && m0_stb;
      d0 = s_rdat;
    end else if (own[k] == 1) begin
      {a, d, we, sel, stb, cyc} = {m1_addr, m1_wdat, m1_we, m1_sel, m1_stb, m1_cyc};
      a1 = s_ack && m1_cyc && m1_stb;
      d1 = s_rdat;
    end
    t = timed_out(k);
    if (t) begin
      stb = 1'b0;
      cyc = 1'b0;
      if (own[k] == 0) begin a0 = 1'b1; d0 = '0; end
      else             begin a1 = 1'b1; d1 = '0; end
    end
    return {a, d, we, sel, stb, cyc, a0, d0, a1, d1, t};
  endfunction

  function automatic logic [137:0] act_vec(int k);
    logic t;
`ifdef WB_ARB_TIMEOUT_EN
    t = tmo_o[k];
`else
    t = 1'b0;
`endif
    return {s_addr_o[k], s_data_o[k], s_we_o[k], s_sel_o[k], s_stb_o[k], s_cyc_o[k],
            m0_ack_o[k], m0_data_o[k], m1_ack_o[k], m1_data_o[k], t};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        own[k] = -1; last[k] = 1; cnt[k] = 0;
      end else if (own[k] < 0) begin
        int pick;
        logic r0, r1;
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        pick = -1;
        if (r0 && r1)  pick = (k == 0) ? 0 : 1 - last[k];
        else if (r0)   pick = 0;
        else if (r1)   pick = 1;
        if (pick >= 0) begin own[k] = pick; last[k] = pick; cnt[k] = 0; end
      end else if (!owner_cyc(k) || timed_out(k)) begin
        own[k] = -1;
      end else begin
        cnt[k] = s_ack ? 0 : cnt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [137:0] e, a;
        e = exp_vec(k);
        a = act_vec(k);
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL model_p%0d actual=%h required=%h t=%0t", k, a, e, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all(int n);
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = '0;
    repeat (n) step();
  endtask

  initial begin
    int who;
    int h0, h1;
    int eo [4] = '{0, 1, 0, 1};
    rst = 1'b1;
    {m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat} = '0;
    {m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack} = '0;
    m0_sel = 4'hF; m1_sel = 4'hF;
    // Reset with both masters requesting: nothing may reach the slave.
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    repeat (3) step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cyc", 32'(s_cyc_o[k]), 32'd0);
      chk("rst_acks", 32'({m0_ack_o[k], m1_ack_o[k]}), 32'd0);
      chk("rst_addr", s_addr_o[k], 32'd0);
    end
    rst = 1'b0;
    idle_all(0);
    chk_en = 1'b1;
    step();

    // M1 alone reads 0x100, slave acks two cycles after the strobe.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h0000_0100;
    @(negedge clk); chk("t1_latency", 32'(s_cyc_o[0]), 32'd0);
    step();
    @(negedge clk); chk("t1_cyc", 32'(s_cyc_o[0]), 32'd1); chk("t1_addr", s_addr_o[0], 32'h100);
    step();
    step(); s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_ack", 32'(m1_ack_o[0]), 32'd1);
    chk("t1_data", m1_data_o[0], 32'hDEAD_BEEF);
    chk("t1_m0_ack", 32'(m0_ack_o[0]), 32'd0);
    step(); idle_all(2);

    // Simultaneous requests: M0 first, one idle cycle, then M1.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'hA0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'hB0;
    step();
    @(negedge clk); chk("t2_m0_gnt", s_addr_o[0], 32'hA0); chk("t2_cyc", 32'(s_cyc_o[0]), 32'd1);
    step(); s_ack = 1'b1; s_rdat = 32'h11;
    @(negedge clk); chk("t2_acks", 32'({m0_ack_o[0], m1_ack_o[0]}), 32'd2);
    step(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk); chk("t2_drop", 32'(s_cyc_o[0]), 32'd0);
    step();
    @(negedge clk); chk("t2_idle", 32'(s_cyc_o[0]), 32'd0);
    step();
    @(negedge clk); chk("t2_m1_gnt", s_addr_o[0], 32'hB0); chk("t2_m1_cyc", 32'(s_cyc_o[0]), 32'd1);
    step(); s_ack = 1'b1;
    step(); idle_all(3);

    // Round-robin with both masters re-requesting after every single beat.
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); s_ack = 1'b1;
      @(negedge clk);
      who = !s_cyc_o[1] ? 2 : (s_addr_o[1] == 32'hA0) ? 0 : 1;
      chk("t3_rr_order", 32'(who), 32'(eo[i]));
      step(); s_ack = 1'b0;
      if (who == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      if (who == 1) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      step(); m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    end
    idle_all(8);

    // M0 flushes before ack; the late ack goes nowhere; pending M1 follows.
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step(); m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clk); chk("t4_m0_gnt", s_addr_o[0], 32'hA0);
    step(); m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk); chk("t4_flush_cyc", 32'(s_cyc_o[0]), 32'd0);
    step(); s_ack = 1'b1;
    @(negedge clk); chk("t4_late_ack", 32'({m0_ack_o[0], m1_ack_o[0]}), 32'd0);
    step(); s_ack = 1'b0;
    @(negedge clk); chk("t4_m1_gnt", s_addr_o[0], 32'hB0);
    idle_all(3);

    // Reset in the middle of an M0 grant.
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step(); rst = 1'b1;
    step(); s_ack = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("t5_cyc_stb", 32'({s_cyc_o[k], s_stb_o[k]}), 32'd0);
      chk("t5_acks", 32'({m0_ack_o[k], m1_ack_o[k]}), 32'd0);
    end
    step(); rst = 1'b0;
    idle_all(3);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: watchdog fires in the 16th granted cycle.
    m0_cyc = 1'b1; m0_stb = 1'b1; s_rdat = 32'h1234_5678;
    for (int c = 1; c <= 16; c++) begin
      step();
      @(negedge clk);
      if (c == 15) chk("t6_no_early", 32'({m0_ack_o[0], tmo_o[0]}), 32'd0);
    end
    chk("t6_ack", 32'(m0_ack_o[0]), 32'd1);
    chk("t6_data", m0_data_o[0], 32'd0);
    chk("t6_tmo", 32'(tmo_o[0]), 32'd1);
    chk("t6_cyc", 32'(s_cyc_o[0]), 32'd0);
    step();
    @(negedge clk); chk("t6_idle", 32'(s_cyc_o[0]), 32'd0);
    idle_all(3);
`endif

    // Random traffic checked cycle by cycle against the model.
    h0 = 0; h1 = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      s_ack = ($urandom_range(0, 2) == 0);
      s_rdat = $urandom;
      if (h0 == 0) begin
        m0_cyc = 1'b0; m0_stb = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          h0 = $urandom_range(1, 6);
          m0_addr = $urandom; m0_wdat = $urandom; m0_we = 1'($urandom); m0_sel = 4'($urandom);
        end
      end
      if (h0 > 0) begin m0_cyc = 1'b1; m0_stb = ($urandom_range(0, 3) != 0); h0--; end
      if (h1 == 0) begin
        m1_cyc = 1'b0; m1_stb = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          h1 = $urandom_range(1, 6);
          m1_addr = $urandom; m1_wdat = $urandom; m1_we = 1'($urandom); m1_sel = 4'($urandom);
        end
      end
      if (h1 > 0) begin m1_cyc = 1'b1; m1_stb = ($urandom_range(0, 3) != 0); h1--; end
    end
    rst = 1'b0;
    idle_all(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
